// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM encoding and byte/word geometry.
// Optional checksum phase is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 128;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int PACK_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [LANE_W-1:0] top_lane();
    return LANE_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: places stream bytes into a word, lane 0 first.
// Lane counter wraps after the top lane; clear wins over load.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        data,
  output logic [PACK_W-1:0] word,
  output logic              last_lane
);

  logic [LANE_W-1:0] lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= data;
      lane <= lane + 1'b1;
    end
  end

  assign last_lane = (lane == top_lane());

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte stream to instruction-memory writer.
// Define IMEM_LOADER_CHECKSUM_EN to append a 4-byte sum check.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CNT_SIZE   = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_SIZE-1:0]   len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [CNT_SIZE-1:0]   mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  mem_wr_en,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t              state;
  logic [CNT_SIZE-1:0] len_q;
  logic                fire;
  logic                pk_clear;
  logic                last_lane;
  logic                last_word;
  logic                too_long;
  logic [PACK_W-1:0]   word;

  assign fire      = byte_valid & byte_ready;
  assign too_long  = (len > CNT_SIZE'(DEPTH));
  assign last_word = (mem_addr == len_q - CNT_SIZE'(1));
  assign pk_clear  = ((state == S_IDLE) & start)
                   | (state == S_WRITE);
  assign mem_data  = word;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (fire),
    .data      (byte_data),
    .word      (word),
    .last_lane (last_lane)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [PACK_W-1:0] sum_q;
  logic              sum_ok;

  // top byte is still on the bus when the last lane transfers
  assign sum_ok = ({byte_data, word[PACK_W-9:0]} == sum_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      mem_addr   <= '0;
      mem_wr_en  <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (too_long) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              if (len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state      <= S_RECV;
                len_q      <= len;
                mem_addr   <= '0;
                byte_ready <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
              end
            end
          end
        end
        S_RECV: begin
          if (fire && last_lane) begin
            state      <= S_WRITE;
            byte_ready <= 1'b0;
            mem_wr_en  <= 1'b1;
          end
        end
        S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + word;
`endif
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CHECK;
            byte_ready <= 1'b1;
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end else begin
            state      <= S_RECV;
            mem_addr   <= mem_addr + CNT_SIZE'(1);
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (fire && last_lane) begin
            byte_ready <= 1'b0;
            if (sum_ok) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_IDLE;
              err      <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end
          end
        end
`endif
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for the imem_loader byte stream.
// Writes are logged at negedge and compared against fixed words.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK = 4;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr_en;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr_en  (mem_wr_en),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int n_busy = 0;
  int n_done = 0;
  int n_wr = 0;
  int n_hold_bad = 0;
  int n_done_idle = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (done) n_done++;
    if (done && !busy) n_done_idle++;
    if (busy != cpu_hold) n_hold_bad++;
    if (mem_wr_en) begin
      n_wr++;
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
  end

  int b0, d0, w0, h0, i0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b0 = n_busy;
    d0 = n_done;
    w0 = n_wr;
    h0 = n_hold_bad;
    i0 = n_done_idle;
  endtask

  task automatic kick(input logic [31:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) push(w[8*k +: 8], gap);
  endtask

  task automatic finish_sum(input logic [31:0] s);
    if (CHK != 0) push_word(s, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] wpat(input int i);
    return {8'(i), 8'hc3, 8'(i), 8'h3c};
  endfunction

  localparam logic [31:0] W0 = 32'h00500093;
  localparam logic [31:0] W1 = 32'h00a00113;
  localparam logic [31:0] W2 = 32'h002081b3;

  initial begin
    logic [31:0] s;
    rst        = 1'b0;
    start      = 1'b0;
    len        = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_flags",
          32'({mem_wr_en, cpu_hold, busy, done, err}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // single word at full rate
    snap();
    kick(32'd1);
    check("one_busy_rise", 32'(busy), 32'd1);
    check("one_ready", 32'(byte_ready), 32'd1);
    push_word(32'h00000013, 0);
    finish_sum(32'h00000013);
    wait_idle();
    check("one_busy_cyc", 32'(n_busy - b0), 32'(6 + CHK));
    check("one_nwr", 32'(n_wr - w0), 32'd1);
    check("one_addr", wa[w0], 32'd0);
    check("one_data", wd[w0], 32'h00000013);
    check("one_done", 32'(n_done - d0), 32'd1);
    check("one_done_in_busy", 32'(n_done_idle - i0), 32'd0);

    // three words, byte_valid toggling
    snap();
    kick(32'd3);
    push_word(W0, 1);
    push_word(W1, 1);
    push_word(W2, 1);
    s = W0 + W1 + W2;
    finish_sum(s);
    wait_idle();
    check("three_nwr", 32'(n_wr - w0), 32'd3);
    check("three_a0", wa[w0], 32'd0);
    check("three_a1", wa[w0+1], 32'd1);
    check("three_a2", wa[w0+2], 32'd2);
    check("three_d0", wd[w0], W0);
    check("three_d1", wd[w0+1], W1);
    check("three_d2", wd[w0+2], W2);
    check("three_done", 32'(n_done - d0), 32'd1);
    check("three_hold", 32'(n_hold_bad - h0), 32'd0);

    // len beyond depth
    snap();
    kick(32'd129);
    check("big_err", 32'(err), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("big_busy_cyc", 32'(n_busy - b0), 32'd0);
    check("big_nwr", 32'(n_wr - w0), 32'd0);

    // zero length
    snap();
    kick(32'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err_clr", 32'(err), 32'd0);
    wait_idle();
    check("zero_busy_cyc", 32'(n_busy - b0), 32'd1);
    check("zero_nwr", 32'(n_wr - w0), 32'd0);
    check("zero_ndone", 32'(n_done - d0), 32'd1);

    // full depth
    snap();
    s = '0;
    kick(32'd128);
    for (int i = 0; i < 128; i++) begin
      push_word(wpat(i), 0);
      s = s + wpat(i);
    end
    finish_sum(s);
    wait_idle();
    check("full_nwr", 32'(n_wr - w0), 32'd128);
    check("full_last_addr", wa[w0+127], 32'd127);
    check("full_last_data", wd[w0+127], 32'h7fc37f3c);
    check("full_err", 32'(err), 32'd0);
    check("full_done", 32'(n_done - d0), 32'd1);
    check("full_busy_cyc", 32'(n_busy - b0), 32'(641 + CHK));

    // start during RECV is ignored
    snap();
    kick(32'd2);
    push(8'h11, 0);
    push(8'h22, 0);
    start = 1'b1;
    len   = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("bstart_addr", mem_addr, 32'd0);
    check("bstart_busy", 32'(busy), 32'd1);
    push(8'h33, 0);
    push(8'h44, 0);
    push_word(32'h88776655, 0);
    finish_sum(32'h44332211 + 32'h88776655);
    wait_idle();
    check("bstart_nwr", 32'(n_wr - w0), 32'd2);
    check("bstart_d0", wd[w0], 32'h44332211);
    check("bstart_a1", wa[w0+1], 32'd1);
    check("bstart_done", 32'(n_done - d0), 32'd1);

    // reset during the third word
    snap();
    kick(32'd3);
    push_word(32'hdeadbeef, 0);
    push_word(32'h12345678, 0);
    push(8'h0d, 0);
    push(8'hf0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_flags",
          32'({byte_ready, mem_wr_en, cpu_hold, busy, done, err}),
          32'd0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_data", mem_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_nwr", 32'(n_wr - w0), 32'd2);
    check("abort_d0", wd[w0], 32'hdeadbeef);
    check("abort_d1", wd[w0+1], 32'h12345678);
    check("abort_ndone", 32'(n_done - d0), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    snap();
    kick(32'd2);
    push_word(32'h1, 0);
    push_word(32'h2, 0);
    push_word(32'h3, 0);
    wait_idle();
    check("sum_ok_done", 32'(n_done - d0), 32'd1);
    check("sum_ok_err", 32'(err), 32'd0);
    snap();
    kick(32'd2);
    push_word(32'h1, 0);
    push_word(32'h2, 0);
    push_word(32'h4, 0);
    wait_idle();
    check("sum_bad_done", 32'(n_done - d0), 32'd0);
    check("sum_bad_err", 32'(err), 32'd1);
    check("sum_bad_nwr", 32'(n_wr - w0), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
